// File: rtl/sb_cfg_dbuf.sv
// Corner switch block: 4:1 routing muxes per output track, configured through
// a ccff shift chain into a shadow register that is committed atomically.
module sb_cfg_dbuf #(
    parameter int CHAN_W = 5,
    parameter int NPIN   = 2
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic [CHAN_W-1:0] chanx_right_in,
    input  logic [CHAN_W-1:0] chany_bottom_in,
    input  logic [NPIN-1:0]   grid_pin_in,
    output logic [CHAN_W-1:0] chanx_right_out,
    output logic [CHAN_W-1:0] chany_bottom_out,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              ccff_commit,
    output logic              ccff_tail,
    output logic              cfg_full,
    output logic              cfg_err
);

    localparam int CFG_BITS = 4 * CHAN_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                full;

    assign full      = (cnt_q == CNT_W'(CFG_BITS));
    assign cfg_full  = full;
    assign cfg_err   = err_q;
    assign ccff_tail = shadow_q[CFG_BITS-1];

    // Commit wins over shift; a premature commit only raises the sticky error.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (ccff_commit) begin
            if (full) begin
                active_d = shadow_q;
                cnt_d    = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (ccff_en) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            shadow_q <= '0;
            active_q <= '1;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    function automatic logic mux4(
        input logic [1:0] sel,
        input logic       a,
        input logic       b,
        input logic       c
    );
        logic y;
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    for (genvar i = 0; i < CHAN_W; i++) begin : g_mux
        localparam int XN = (i + 1) % CHAN_W;
        localparam int YP = (i + CHAN_W - 1) % CHAN_W;
        localparam int GX = i % NPIN;
        localparam int GY = (i + 1) % NPIN;

        assign chanx_right_out[i] = mux4(
            active_q[2*i +: 2],
            chany_bottom_in[i],
            chany_bottom_in[XN],
            grid_pin_in[GX]);

        assign chany_bottom_out[i] = mux4(
            active_q[2*(CHAN_W+i) +: 2],
            chanx_right_in[i],
            chanx_right_in[YP],
            grid_pin_in[GY]);
    end

endmodule
